// File: rtl/tarhi_mem_if.sv
// tarhi_mem_if
//   CPU memory-port bundle plus the TX byte stream leaving the memory system.
//   The master side is the environment around the memory system: the CPU that
//   drives address/strobe/data, and the downstream consumer that drives
//   tx_ready. The slave side is tarhi_mem_sys.
//   Signals:
//     cpu_addr  [23:0]  word address from CPU
//     cpu_write         write strobe, one write per sampled-high cycle
//     cpu_wdata [31:0]  write data from CPU
//     cpu_rdata [31:0]  registered read data back to CPU
//     out_reg   [31:0]  general-purpose output register
//     tx_data   [7:0]   head byte of the TX FIFO
//     tx_valid          TX FIFO non-empty
//     tx_ready          consumer accepts tx_data this cycle
interface tarhi_mem_if;
    logic [23:0] cpu_addr;
    logic        cpu_write;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [31:0] out_reg;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output cpu_addr, cpu_write, cpu_wdata, tx_ready,
        input  cpu_rdata, out_reg, tx_data, tx_valid
    );

    modport slave (
        input  cpu_addr, cpu_write, cpu_wdata, tx_ready,
        output cpu_rdata, out_reg, tx_data, tx_valid
    );
endinterface

// File: rtl/tarhi_mem_sys.sv
// tarhi_mem_sys
//   Memory subsystem behind the tarhi CPU memory port. The 24-bit word address
//   space is split into an on-chip single-port RAM (aliased, only the low
//   RAM_AW bits are used) and a memory-mapped I/O page selected by
//   cpu_addr[23:16] == IO_PAGE:
//     0x0000 OUT     R/W 32-bit output register
//     0x0001 TXDATA  write pushes cpu_wdata[7:0] into the TX FIFO, reads 0
//     0x0002 STATUS  {16'h0, occupancy[7:0], 6'h0, full, empty}
//     0x0003 DROPS   16-bit saturating count of pushes lost while full;
//                    any write clears it
//   Read data is registered (1-cycle latency, read-before-write).
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    tarhi_mem_if.slave (CPU port + TX stream)
//   Build option:
//     TARHI_TXPUSH_EDGE_EN  when defined, only the first cycle of a run of
//                           consecutive TXDATA write cycles pushes a byte.
module tarhi_mem_sys #(
    parameter int          RAM_AW     = 10,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  IO_PAGE    = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    tarhi_mem_if.slave    bus
);

    localparam int RAM_WORDS = 1 << RAM_AW;
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;

    localparam logic [15:0]   OFF_OUT    = 16'h0000;
    localparam logic [15:0]   OFF_TXDATA = 16'h0001;
    localparam logic [15:0]   OFF_STATUS = 16'h0002;
    localparam logic [15:0]   OFF_DROPS  = 16'h0003;
    localparam logic [PW-1:0] PTR_ONE    = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
    localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);

    // Storage arrays: not reset, contents survive reset.
    logic [31:0]   ram_mem_r  [RAM_WORDS];
    logic [7:0]    fifo_mem_r [FIFO_DEPTH];

    // Control state
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          tx_valid_r;
    logic [15:0]   drops_r;
    logic [31:0]   out_reg_r;
    logic [31:0]   cpu_rdata_r;

    // Decode / control signals
    logic              io_sel_s;
    logic [15:0]       io_off_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              wr_s;
    logic              ram_we_s;
    logic              out_we_s;
    logic              tx_wr_s;
    logic              drops_wr_s;
    logic              push_req_s;
    logic              push_ok_s;
    logic              drop_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     count_nxt_s;
    logic [31:0]       status_s;
    logic [31:0]       io_rdata_s;

    // Address decode and per-target write enables; nothing is written in a reset cycle.
    always_comb begin
        io_sel_s   = (bus.cpu_addr[23:16] == IO_PAGE);
        io_off_s   = bus.cpu_addr[15:0];
        ram_idx_s  = bus.cpu_addr[RAM_AW-1:0];
        wr_s       = bus.cpu_write && !reset;
        ram_we_s   = wr_s && !io_sel_s;
        out_we_s   = wr_s && io_sel_s && (io_off_s == OFF_OUT);
        tx_wr_s    = wr_s && io_sel_s && (io_off_s == OFF_TXDATA);
        drops_wr_s = wr_s && io_sel_s && (io_off_s == OFF_DROPS);
    end

`ifdef TARHI_TXPUSH_EDGE_EN
    logic tx_wr_prev_r;

    // Remember whether the previous cycle was a TXDATA write so a held strobe pushes once.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_prev_r <= 1'b0;
        end else begin
            tx_wr_prev_r <= tx_wr_s;
        end
    end

    assign push_req_s = tx_wr_s && !tx_wr_prev_r;
`else
    assign push_req_s = tx_wr_s;
`endif

    // FIFO push/pop arbitration; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        fifo_full_s  = (count_r == CNT_FULL);
        fifo_empty_s = (count_r == CNT_ZERO);
        pop_s        = tx_valid_r && bus.tx_ready;
        push_ok_s    = push_req_s && (!fifo_full_s || pop_s);
        drop_s       = push_req_s && fifo_full_s && !pop_s;
        if (push_ok_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_ok_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO pointers, occupancy and the registered non-empty flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= CNT_ZERO;
            tx_valid_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_nxt_s;
            tx_valid_r <= (count_nxt_s != CNT_ZERO);
        end
    end

    // FIFO byte storage.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.cpu_wdata[7:0];
        end
    end

    // RAM word storage.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_mem_r[ram_idx_s] <= bus.cpu_wdata;
        end
    end

    // OUT register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg_r <= 32'h0000_0000;
        end else if (out_we_s) begin
            out_reg_r <= bus.cpu_wdata;
        end
    end

    // Drop counter: a CPU write clears it even when a drop happens in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            drops_r <= 16'h0000;
        end else if (drops_wr_s) begin
            drops_r <= 16'h0000;
        end else if (drop_s && (drops_r != 16'hFFFF)) begin
            drops_r <= drops_r + 16'h0001;
        end
    end

    // I/O page read mux, evaluated on pre-edge state.
    always_comb begin
        status_s = {16'h0000, 8'(count_r), 6'b00_0000, fifo_full_s, fifo_empty_s};
        case (io_off_s)
            OFF_OUT:    io_rdata_s = out_reg_r;
            OFF_TXDATA: io_rdata_s = 32'h0000_0000;
            OFF_STATUS: io_rdata_s = status_s;
            OFF_DROPS:  io_rdata_s = {16'h0000, drops_r};
            default:    io_rdata_s = 32'h0000_0000;
        endcase
    end

    // Registered read data; RAM is read with the old contents of a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_r <= 32'h0000_0000;
        end else if (io_sel_s) begin
            cpu_rdata_r <= io_rdata_s;
        end else begin
            cpu_rdata_r <= ram_mem_r[ram_idx_s];
        end
    end

    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.out_reg   = out_reg_r;
    assign bus.tx_valid  = tx_valid_r;
    assign bus.tx_data   = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_tarhi_mem_sys.sv
// Testbench for tarhi_mem_sys: directed scenarios followed by randomized
// traffic, all checked against a queue/array reference model.
module tb_tarhi_mem_sys;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;

    tarhi_mem_if bus ();

    tarhi_mem_sys #(
        .RAM_AW     (10),
        .FIFO_DEPTH (DEPTH),
        .IO_PAGE    (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ram_m     [1024];
    bit          ram_known [1024];
    byte unsigned txq [$];
    int unsigned drops_m;
    logic [31:0] out_m;
    bit          tx_prev_m;
    logic [31:0] exp_rd;
    bit          exp_rd_ok;
    bit          chk_en;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [23:0] a, output bit ok);
        ok = 1'b1;
        if (a[23:16] == 8'hFF) begin
            case (a[15:0])
                16'h0000: return out_m;
                16'h0002: return {16'h0000, 8'(txq.size()), 6'b0,
                                  txq.size() == DEPTH, txq.size() == 0};
                16'h0003: return 32'(drops_m);
                default:  return 32'h0;
            endcase
        end else begin
            ok = ram_known[a[9:0]];
            return ram_m[a[9:0]];
        end
    endfunction

    // One clock cycle: check outputs at the negedge, drive inputs, advance the model.
    task automatic step(input logic [23:0] a, input bit w, input logic [31:0] d,
                        input bit rdy, input bit rst);
        bit io, txw, push, pop, ok, drop;
        logic [15:0] off;
        if (chk_en) begin
            if (exp_rd_ok) check_eq("cpu_rdata", bus.cpu_rdata, exp_rd);
            check_eq("tx_valid", 32'(bus.tx_valid), 32'(txq.size() != 0));
            if (txq.size() != 0) check_eq("tx_data", 32'(bus.tx_data), 32'(txq[0]));
            check_eq("out_reg", bus.out_reg, out_m);
        end
        bus.cpu_addr  = a;
        bus.cpu_write = w;
        bus.cpu_wdata = d;
        bus.tx_ready  = rdy;
        reset         = rst;
        io   = (a[23:16] == 8'hFF);
        off  = a[15:0];
        drop = 1'b0;
        if (rst) begin
            txq.delete();
            drops_m   = 0;
            out_m     = 32'h0;
            tx_prev_m = 1'b0;
            exp_rd    = 32'h0;
            exp_rd_ok = 1'b1;
        end else begin
            exp_rd    = model_read(a, ok);
            exp_rd_ok = ok;
            pop = (txq.size() != 0) && rdy;
            txw = w && io && (off == 16'h0001);
`ifdef TARHI_TXPUSH_EDGE_EN
            push = txw && !tx_prev_m;
`else
            push = txw;
`endif
            tx_prev_m = txw;
            if (pop) void'(txq.pop_front());
            if (push) begin
                if (txq.size() < DEPTH) txq.push_back(d[7:0]);
                else drop = 1'b1;
            end
            if (w && io && off == 16'h0003) drops_m = 0;
            else if (drop && drops_m < 65535) drops_m++;
            if (w && io && off == 16'h0000) out_m = d;
            if (w && !io) begin
                ram_m[a[9:0]]     = d;
                ram_known[a[9:0]] = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (rst) chk_en = 1'b1;
    endtask

    task automatic idle(input bit rdy);
        step(24'hFF0010, 1'b0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        logic [7:0] seq [8];
        logic [23:0] a;
        exp_rd_ok     = 1'b0;
        chk_en        = 1'b0;
        bus.cpu_addr  = 24'h0;
        bus.cpu_write = 1'b0;
        bus.cpu_wdata = 32'h0;
        bus.tx_ready  = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        step(24'hFF0010, 1'b0, 32'h0, 1'b0, 1'b1);
        step(24'hFF0010, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("rst_rdata", bus.cpu_rdata, 32'h0);
        check_eq("rst_txvalid", 32'(bus.tx_valid), 32'h0);

        // RAM write and aliased reads
        step(24'h000005, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        step(24'h000005, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("ram_rd", bus.cpu_rdata, 32'hDEADBEEF);
        step(24'h400005, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("ram_alias", bus.cpu_rdata, 32'hDEADBEEF);

        // Read-before-write
        step(24'h000010, 1'b1, 32'h7, 1'b0, 1'b0);
        step(24'h000010, 1'b1, 32'h1, 1'b0, 1'b0);
        check_eq("rbw_old", bus.cpu_rdata, 32'h7);
        step(24'h000010, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("rbw_new", bus.cpu_rdata, 32'h1);

        // Overfill with consumer stalled
        for (int i = 1; i <= 10; i++) begin
            step(24'hFF0001, 1'b1, 32'(i), 1'b0, 1'b0);
            idle(1'b0);
        end
        step(24'hFF0002, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("status_full", bus.cpu_rdata, 32'h0000_0802);
        step(24'hFF0003, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("drops_2", bus.cpu_rdata, 32'h2);
        for (int i = 1; i <= 8; i++) begin
            check_eq("drain_valid", 32'(bus.tx_valid), 32'h1);
            check_eq("drain_data", 32'(bus.tx_data), 32'(i));
            idle(1'b1);
        end
        check_eq("drain_empty", 32'(bus.tx_valid), 32'h0);

        // Push into a full FIFO while popping
        for (int i = 0; i < 8; i++) begin
            step(24'hFF0001, 1'b1, 32'h11 + 32'(i), 1'b0, 1'b0);
            idle(1'b0);
        end
        step(24'hFF0001, 1'b1, 32'hAA, 1'b1, 1'b0);
        step(24'hFF0002, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("status_fullpop", bus.cpu_rdata, 32'h0000_0802);
        step(24'hFF0003, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("drops_nodrop", bus.cpu_rdata, 32'h2);
        for (int i = 0; i < 7; i++) seq[i] = 8'h12 + 8'(i);
        seq[7] = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            check_eq("aa_order", 32'(bus.tx_data), 32'(seq[i]));
            idle(1'b1);
        end

        // Reset mid-drain
        step(24'hFF0000, 1'b1, 32'h12345678, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(24'hFF0001, 1'b1, 32'h30 + 32'(i), 1'b0, 1'b0);
            idle(1'b0);
        end
        check_eq("out_set", bus.out_reg, 32'h12345678);
        idle(1'b1);
        step(24'hFF0010, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("rst_out", bus.out_reg, 32'h0);
        check_eq("rst_txv", 32'(bus.tx_valid), 32'h0);
        step(24'hFF0002, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("rst_status", bus.cpu_rdata, 32'h1);

        // Held TXDATA strobe
        for (int i = 0; i < 4; i++) step(24'hFF0001, 1'b1, 32'h55, 1'b0, 1'b0);
        step(24'hFF0002, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef TARHI_TXPUSH_EDGE_EN
        check_eq("held_push", bus.cpu_rdata, 32'h0000_0100);
`else
        check_eq("held_push", bus.cpu_rdata, 32'h0000_0400);
`endif
        step(24'hFF0010, 1'b0, 32'h0, 1'b0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(1, 0) == 1)
                a = {8'hFF, 16'($urandom_range(5, 0))};
            else
                a = {8'($urandom_range(254, 0)), 6'($urandom), 6'b0, 4'($urandom)};
            step(a, $urandom_range(9, 0) < 4, $urandom, $urandom_range(9, 0) < 3,
                 $urandom_range(299, 0) == 0);
        end
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
